// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Word-oriented vectors use big-endian bit numbering: bit 0 is the MSB.
package fetch_queue_pkg;

  localparam int WORD_W = 32;

  typedef logic [0:WORD_W-1] word_t;

  localparam word_t PC_STEP = 32'd4;
  localparam word_t NOP     = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fq_state_e;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  // Instructions are word aligned; the two low-order bits are dropped.
  function automatic word_t align_pc(input word_t pc);
    return {pc[0:WORD_W-3], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory and decode-side handshake bundle of the fetch queue.
// master: the fetch queue itself; slave: memory plus downstream consumer.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  word_t imem_rdata;
  logic  imem_rvalid;
  logic  out_valid;
  word_t out_instr;
  word_t out_pc;
  logic  out_ready;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_rdata, imem_rvalid, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_rdata, imem_rvalid, out_ready
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO of {pc, instr} entries with a flush input.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       clear,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a flush empties the queue in one edge.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  // Entry storage needs no reset: empty slots are never presented.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues word fetches, buffers the
// returned words with their PCs and flushes wrong-path work on a redirect.
// Optional saturating statistics: define FETCH_QUEUE_STATS_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_BOOT  | first cycle after reset, no fetch issued
// ST_RUN   | normal fetch, one request per cycle while a slot is free
// ST_DRAIN | one bubble after a redirect that killed an in-flight response
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  word_t       redirect_pc,
  output word_t       fetch_pc,
`ifdef FETCH_QUEUE_STATS_EN
  output logic [0:15] stat_redirects,
  output logic [0:15] stat_stalls,
`endif
  fetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  fq_state_e        state;
  logic             pending;
  word_t            pend_addr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] occupancy;
  logic             fifo_full;
  logic             fifo_empty;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             issue;
  logic             push;
  logic             pop;

  // A slot is reserved at issue time, so the in-flight request counts as used.
  assign occupancy = count + CNT_W'(pending);
  assign issue     = !reset && (state == ST_RUN) && !redirect_valid &&
                     !fifo_full && (occupancy < CNT_MAX);

  // The response to an outstanding request lands in the cycle after issue;
  // if a redirect arrives in that same cycle the word is wrong-path and dropped.
  assign push       = !reset && bus.imem_rvalid && pending && !redirect_valid;
  assign pop        = bus.out_valid && bus.out_ready;
  assign push_entry = '{pc: pend_addr, instr: bus.imem_rdata};

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_pc    = fifo_empty ? NOP : head.pc;
  assign bus.out_instr = fifo_empty ? NOP : head.instr;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (redirect_valid),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Fetch sequencing: state, fetch PC and the single outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_BOOT;
      fetch_pc  <= PC_RESET;
      pending   <= 1'b0;
      pend_addr <= NOP;
    end else begin
      pending <= issue;
      if (issue) pend_addr <= fetch_pc;
      if (redirect_valid) begin
        fetch_pc <= align_pc(redirect_pc);
        // In DRAIN nothing is outstanding, so this always returns to RUN there.
        state    <= pending ? ST_DRAIN : ST_RUN;
      end else begin
        if (issue) fetch_pc <= fetch_pc + PC_STEP;
        case (state)
          ST_BOOT:  state <= ST_RUN;
          ST_DRAIN: state <= ST_RUN;
          default:  state <= ST_RUN;
        endcase
      end
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  // Saturating counts of redirects and of cycles the consumer stalls the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_redirects <= '0;
      stat_stalls    <= '0;
    end else begin
      if (redirect_valid && (stat_redirects != 16'hFFFF))
        stat_redirects <= stat_redirects + 16'd1;
      if (bus.out_valid && !bus.out_ready && (stat_stalls != 16'hFFFF))
        stat_stalls <= stat_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [0:31] PC_RESET = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [0:31] redirect_pc;
  logic [0:31] fetch_pc;
`ifdef FETCH_QUEUE_STATS_EN
  logic [0:15] stat_redirects;
  logic [0:15] stat_stalls;
`endif

  fetch_queue_if bus ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .PC_RESET (PC_RESET)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_pc       (fetch_pc),
`ifdef FETCH_QUEUE_STATS_EN
    .stat_redirects (stat_redirects),
    .stat_stalls    (stat_stalls),
`endif
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: PC, queue of {pc,instr}, one in-flight fetch, bubble count.
  logic [0:31] m_pc;
  logic [63:0] m_q [$];
  logic        m_inflight;
  logic [0:31] m_inflight_addr;
  int          m_idle;
  int          m_redirects;
  int          m_stalls;

  // Memory responder and sampled DUT values for directed checks.
  logic        cap_req = 1'b0;
  logic [0:31] cap_addr = '0;
  logic [0:31] issued [$];
  logic        s_req;
  logic        s_valid;
  logic [0:31] s_out_pc;
  logic [0:31] s_fetch_pc;
  int          s_stat_redir;
  int          s_stat_stall;

  function automatic logic [0:31] mem_word(input logic [0:31] a);
    return a ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance model.
  task automatic cycle(input logic rst, input logic rv, input logic [0:31] rpc, input logic rdy);
    logic        exp_valid;
    logic        exp_req;
    logic [0:31] exp_pc;
    logic [0:31] exp_instr;
    reset           = rst;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    bus.out_ready   = rdy;
    bus.imem_rvalid = cap_req;
    bus.imem_rdata  = cap_req ? mem_word(cap_addr) : 32'($urandom());
    @(negedge clk);
    exp_valid = (m_q.size() > 0);
    exp_pc    = exp_valid ? m_q[0][63:32] : 32'h0;
    exp_instr = exp_valid ? m_q[0][31:0]  : 32'h0;
    exp_req   = !rst && (m_idle == 0) && !rv && ((m_q.size() + int'(m_inflight)) < DEPTH);
    s_req      = bus.imem_req;
    s_valid    = bus.out_valid;
    s_out_pc   = bus.out_pc;
    s_fetch_pc = fetch_pc;
`ifdef FETCH_QUEUE_STATS_EN
    s_stat_redir = int'(stat_redirects);
    s_stat_stall = int'(stat_stalls);
`endif
    if (!rst) begin
      chk("imem_req",  bus.imem_req,  exp_req);
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("fetch_pc",  fetch_pc,      m_pc);
      chk("out_valid", bus.out_valid, exp_valid);
      chk("out_pc",    bus.out_pc,    exp_pc);
      chk("out_instr", bus.out_instr, exp_instr);
`ifdef FETCH_QUEUE_STATS_EN
      chk("stat_redirects", stat_redirects, m_redirects);
      chk("stat_stalls",    stat_stalls,    m_stalls);
`endif
    end
    cap_req  = bus.imem_req;
    cap_addr = bus.imem_addr;
    if (cap_req) issued.push_back(cap_addr);
    @(posedge clk);
    if (rst) begin
      m_pc        = PC_RESET;
      m_q.delete();
      m_inflight  = 1'b0;
      m_idle      = 1;
      m_redirects = 0;
      m_stalls    = 0;
    end else begin
      if (exp_valid && !rdy && m_stalls < 65535) m_stalls++;
      if (exp_valid && rdy) void'(m_q.pop_front());
      if (rv) begin
        if (m_redirects < 65535) m_redirects++;
        m_q.delete();
        m_idle     = m_inflight ? 1 : 0;
        m_inflight = 1'b0;
        m_pc       = {rpc[0:29], 2'b00};
      end else begin
        if (m_inflight) m_q.push_back({m_inflight_addr, mem_word(m_inflight_addr)});
        if (m_idle > 0) m_idle--;
        m_inflight = exp_req;
        if (exp_req) begin
          m_inflight_addr = m_pc;
          m_pc            = m_pc + 32'd4;
        end
      end
    end
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bus.out_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    m_pc = PC_RESET; m_inflight = 1'b0; m_inflight_addr = '0; m_idle = 1;
    m_redirects = 0; m_stalls = 0;
    s_stat_redir = 0; s_stat_stall = 0;
    @(posedge clk);
    #1;

    // Reset, then stream with out_ready high.
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    issued.delete();
    cycle(0, 0, 0, 1);
    chk("boot_no_req", s_req, 1'b0);
    chk("boot_empty", s_valid, 1'b0);
    repeat (8) cycle(0, 0, 0, 1);
    chk("stream_a0", issued[0], 32'h0);
    chk("stream_a1", issued[1], 32'h4);
    chk("stream_a2", issued[2], 32'h8);
    chk("stream_a3", issued[3], 32'hC);

    // Fill with out_ready low: exactly DEPTH requests, head held at pc 0.
    cycle(1, 0, 0, 0);
    issued.delete();
    repeat (10) cycle(0, 0, 0, 0);
    chk("full_nreq", issued.size(), DEPTH);
    chk("full_req_low", s_req, 1'b0);
    chk("full_valid", s_valid, 1'b1);
    chk("full_head_pc", s_out_pc, 32'h0);
    repeat (6) cycle(0, 0, 0, 1);
    chk("resume_addr", issued[4], 32'h10);

    // Redirect to 0x40 while a fetch is in flight.
    repeat (3) cycle(0, 0, 0, 1);
    issued.delete();
    cycle(0, 1, 32'h0000_0040, 1);
    repeat (6) cycle(0, 0, 0, 1);
    chk("redir_first", issued[0], 32'h40);

    // Unaligned redirect target.
    issued.delete();
    cycle(0, 1, 32'h0000_0043, 1);
    repeat (4) cycle(0, 0, 0, 1);
    chk("redir_align", issued[0], 32'h40);

    // Reset wins over a simultaneous redirect.
    cycle(1, 1, 32'h0000_0080, 1);
    cycle(0, 0, 0, 1);
    chk("rst_redir_pc", s_fetch_pc, PC_RESET);
    chk("rst_redir_empty", s_valid, 1'b0);
    repeat (3) cycle(0, 0, 0, 1);

    // PC wrap-around.
    issued.delete();
    cycle(0, 1, 32'hFFFF_FFF8, 1);
    repeat (6) cycle(0, 0, 0, 1);
    chk("wrap_a0", issued[0], 32'hFFFF_FFF8);
    chk("wrap_a1", issued[1], 32'hFFFF_FFFC);
    chk("wrap_a2", issued[2], 32'h0000_0000);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
            32'($urandom()), ($urandom_range(0, 3) != 0));
    end

`ifdef FETCH_QUEUE_STATS_EN
    // Three redirects and five stall cycles after a clean reset.
    cycle(1, 0, 0, 1);
    repeat (4) cycle(0, 0, 0, 1);
    repeat (5) cycle(0, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      cycle(0, 1, 32'h0000_0100, 1);
      repeat (3) cycle(0, 0, 0, 1);
    end
    cycle(0, 0, 0, 1);
    chk("stats_redirects", s_stat_redir, 3);
    chk("stats_stalls", s_stat_stall, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
